// File: rtl/fp16_mult_arbiter_if.sv
// Requester-side bus of the shared FP16 multiplier: operand handshake plus response strobe.
// The master modport is the requester side and the slave modport is the arbiter side.
interface fp16_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fp16_mult_arbiter.sv
// Round-robin sharing of one fixed-latency fp16_mult between NUM_REQ requesters.
// A tag shift register follows each product through the IP and routes the result back to its issuer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ISSUE   | arbitration enabled, one operand pair per cycle at most
// ST_DRAIN   | no grants; waiting for every tracked product to emerge
// ST_DRAINED | pipeline empty, flush_done high until flush_req drops
module fp16_mult_arbiter #(
    parameter int  NUM_REQ      = 4,
    parameter int  MULT_LATENCY = 6,
    localparam int TAG_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    fp16_mult_arbiter_if.slave req_if,
    output logic [15:0]        mult_a,
    output logic [15:0]        mult_b,
    input  logic [31:0]        mult_result,
    input  logic               mult_result_valid,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               busy,
    output logic               err_desync
);
    localparam int DEPTH = MULT_LATENCY + 1;

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t                      state_q, state_d;
    logic [TAG_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0]            slot_vld_q, slot_vld_d;
    logic [DEPTH-1:0][TAG_W-1:0] slot_tag_q, slot_tag_d;
    logic [15:0]                 mult_a_q, mult_a_d;
    logic [15:0]                 mult_b_q, mult_b_d;
    logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
    logic [31:0]                 resp_data_q, resp_data_d;
    logic                        err_desync_q, err_desync_d;

    logic                        arb_en;
    logic                        grant_any;
    logic [TAG_W-1:0]            grant_idx;
    logic                        xfer;

    // First asserted request at or after the pointer, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_if.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign arb_en           = (state_q == ST_ISSUE) && !flush_req && !rst;
    assign xfer             = arb_en && grant_any;
    assign req_if.req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        err_desync_d = err_desync_q;

        case (state_q)
            ST_ISSUE:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN:   if (slot_vld_q == '0) state_d = ST_DRAINED;
            ST_DRAINED: if (!flush_req) state_d = ST_ISSUE;
            default:    state_d = ST_ISSUE;
        endcase

        if (xfer) begin
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // Idle cycles push zero operands so the IP never sees stale data.
        slot_vld_d = {slot_vld_q[DEPTH-2:0], xfer};
        slot_tag_d = {slot_tag_q[DEPTH-2:0], grant_idx};
        mult_a_d   = xfer ? req_if.req_a[16*grant_idx +: 16] : 16'h0000;
        mult_b_d   = xfer ? req_if.req_b[16*grant_idx +: 16] : 16'h0000;

        // Response is delivered even when the IP failed to flag it; the error is sticky.
        if (slot_vld_q[DEPTH-1]) begin
            resp_valid_d = NUM_REQ'(1) << slot_tag_q[DEPTH-1];
            resp_data_d  = mult_result;
            if (!mult_result_valid) err_desync_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ISSUE;
            rr_ptr_q     <= '0;
            slot_vld_q   <= '0;
            slot_tag_q   <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_desync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            slot_vld_q   <= slot_vld_d;
            slot_tag_q   <= slot_tag_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_desync_q <= err_desync_d;
        end
    end

    assign mult_a            = mult_a_q;
    assign mult_b            = mult_b_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign flush_done        = (state_q == ST_DRAINED);
    assign busy              = !rst && ((slot_vld_q != '0) || xfer);
    assign err_desync        = err_desync_q;
endmodule
